// File: rtl/link_latency_monitor_pkg.sv
// Shared types and helpers for the multi-lane link latency monitor.
//   lane_state_e     : per-lane RX checker state
//   k_width()        : K-flag width for a given symbol width
//   cnt_width()      : counter width able to hold 0..max_val
//   Idle*Default     : default IDLE word / K-flags before zero-extension
package link_latency_monitor_pkg;

   typedef enum logic [2:0] {
      StUnsync,
      StBlind,
      StAlign,
      StCheck,
      StFail
   } lane_state_e;

   localparam logic [15:0] IdleWordDefault = 16'hbc95;
   localparam logic [1:0]  IdleKDefault    = 2'b10;

   function automatic int unsigned k_width(input int unsigned data_width);
      return data_width / 8;
   endfunction

   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/link_latency_lane.sv
// One RX lane checker: comma alignment FSM, elastic-buffer health, latency statistics.
//   clk_i / rst_n_i      : clock, asynchronous active-low reset
//   clear_i              : clear statistics and sticky flags (FSM FAIL -> ALIGN)
//   ts_i                 : shared free-running timestamp
//   rx_data_i / rx_k_i   : received symbol and K-flags
//   rx_synced_i          : comma alignment achieved
//   rx_buf_err_i         : elastic buffer over/underflow
//   rx_rdy_i             : local RX ready
//   rx_resync_o          : realignment request
//   fail_o               : lane failed or not yet passed
//   fail_comma_o         : sticky wrong-comma flag
//   fail_buffer_o        : sticky buffer-error flag
//   latency_*_o          : last/min/max latency and accumulated sum
// Build option: LINK_LATENCY_MONITOR_SUM_EN builds the saturating latency accumulator.
module link_latency_lane
   import link_latency_monitor_pkg::*;
#(
   parameter int unsigned                  g_DATA_WIDTH          = 16,
   parameter int unsigned                  g_K_WIDTH             = 2,
   parameter logic [g_DATA_WIDTH-1:0]      g_IDLE_W              = '0,
   parameter logic [g_K_WIDTH-1:0]         g_IDLE_K_W            = '0,
   parameter int unsigned                  g_BLIND_PERIOD        = 10,
   parameter int unsigned                  g_NUM_SUCCESSFUL_DATA = 1000
) (
   input  logic                        clk_i,
   input  logic                        rst_n_i,
   input  logic                        clear_i,
   input  logic [g_DATA_WIDTH-1:0]     ts_i,
   input  logic [g_DATA_WIDTH-1:0]     rx_data_i,
   input  logic [g_K_WIDTH-1:0]        rx_k_i,
   input  logic                        rx_synced_i,
   input  logic                        rx_buf_err_i,
   input  logic                        rx_rdy_i,
   output logic                        rx_resync_o,
   output logic                        fail_o,
   output logic                        fail_comma_o,
   output logic                        fail_buffer_o,
   output logic [g_DATA_WIDTH-1:0]     latency_last_o,
   output logic [g_DATA_WIDTH-1:0]     latency_min_o,
   output logic [g_DATA_WIDTH-1:0]     latency_max_o,
   output logic [g_DATA_WIDTH+15:0]    latency_sum_o
);

   localparam int unsigned BlindW = cnt_width(g_BLIND_PERIOD);
   localparam int unsigned SampW  = cnt_width(g_NUM_SUCCESSFUL_DATA);
   localparam int unsigned SumW   = g_DATA_WIDTH + 16;
   localparam logic [BlindW-1:0] BlindLast = BlindW'(g_BLIND_PERIOD - 1);
   localparam logic [SampW-1:0]  SampMax   = SampW'(g_NUM_SUCCESSFUL_DATA);

   lane_state_e               state_q, state_d;
   logic [BlindW-1:0]         blind_q, blind_d;
   logic                      comma_q, comma_d;
   logic                      buffer_q, buffer_d;
   logic                      resync_q;
   logic [SampW-1:0]          samp_cnt_q, samp_cnt_d;
   logic [g_DATA_WIDTH-1:0]   lat_q, lat_d;
   logic                      lat_vld_q, lat_vld_d;
   logic [g_DATA_WIDTH-1:0]   last_q, last_d, min_q, min_d, max_q, max_d;
   logic                      is_idle, k_zero;

   assign is_idle = (rx_data_i == g_IDLE_W) && (rx_k_i == g_IDLE_K_W);
   assign k_zero  = (rx_k_i == '0);

   // Lane FSM and sticky flags. Clear is applied first so a same-cycle comma error still
   // lands; loss of sync overrides everything.
   always_comb begin
      state_d   = state_q;
      blind_d   = blind_q;
      comma_d   = comma_q;
      buffer_d  = buffer_q;
      lat_vld_d = 1'b0;
      if (clear_i) begin
         comma_d  = 1'b0;
         buffer_d = 1'b0;
      end
      unique case (state_q)
         StUnsync: begin
            blind_d = '0;
            if (rx_synced_i) state_d = StBlind;
         end
         StBlind: begin
            if (blind_q == BlindLast) state_d = StAlign;
            else                      blind_d = blind_q + 1'b1;
         end
         StAlign: begin
            if (is_idle) begin
               state_d = StCheck;
            end else if (!k_zero) begin
               state_d = StFail;
               comma_d = 1'b1;
            end
         end
         StCheck: begin
            if (k_zero) begin
               lat_vld_d = ~clear_i;
            end else if (!is_idle) begin
               state_d = StFail;
               comma_d = 1'b1;
            end
         end
         StFail: begin
            if (clear_i) state_d = StAlign;
         end
         default: state_d = StUnsync;
      endcase
      if (rx_buf_err_i && rx_synced_i && (state_q != StUnsync)) buffer_d = 1'b1;
      if (!rx_synced_i) begin
         state_d   = StUnsync;
         comma_d   = 1'b0;
         buffer_d  = 1'b0;
         lat_vld_d = 1'b0;
      end
   end

   // Modular subtraction keeps the result correct across timestamp wrap.
   assign lat_d = ts_i - rx_data_i;

   always_comb begin
      samp_cnt_d = samp_cnt_q;
      if (!rx_synced_i || clear_i) begin
         samp_cnt_d = '0;
      end else if (lat_vld_q && (samp_cnt_q != SampMax)) begin
         samp_cnt_d = samp_cnt_q + 1'b1;
      end
   end

   always_comb begin
      last_d = last_q;
      min_d  = min_q;
      max_d  = max_q;
      if (clear_i) begin
         last_d = '0;
         min_d  = '1;
         max_d  = '0;
      end else if (lat_vld_q) begin
         last_d = lat_q;
         if (lat_q < min_q) min_d = lat_q;
         if (lat_q > max_q) max_d = lat_q;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q    <= StUnsync;
         blind_q    <= '0;
         comma_q    <= 1'b0;
         buffer_q   <= 1'b0;
         resync_q   <= 1'b0;
         samp_cnt_q <= '0;
         lat_q      <= '0;
         lat_vld_q  <= 1'b0;
         last_q     <= '0;
         min_q      <= '1;
         max_q      <= '0;
      end else begin
         state_q    <= state_d;
         blind_q    <= blind_d;
         comma_q    <= comma_d;
         buffer_q   <= buffer_d;
         resync_q   <= rx_rdy_i & ~rx_synced_i;
         samp_cnt_q <= samp_cnt_d;
         lat_q      <= lat_d;
         lat_vld_q  <= lat_vld_d;
         last_q     <= last_d;
         min_q      <= min_d;
         max_q      <= max_d;
      end
   end

`ifdef LINK_LATENCY_MONITOR_SUM_EN
   logic [SumW-1:0] sum_q, sum_d;
   logic [SumW:0]   sum_ext;

   always_comb begin
      sum_ext = {1'b0, sum_q} + {{(SumW + 1 - g_DATA_WIDTH){1'b0}}, lat_q};
      sum_d   = sum_q;
      if (clear_i) begin
         sum_d = '0;
      end else if (lat_vld_q) begin
         sum_d = sum_ext[SumW] ? '1 : sum_ext[SumW-1:0];
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) sum_q <= '0;
      else          sum_q <= sum_d;
   end

   assign latency_sum_o = sum_q;
`else
   assign latency_sum_o = '0;
`endif

   assign rx_resync_o    = resync_q;
   assign fail_comma_o   = comma_q;
   assign fail_buffer_o  = buffer_q;
   assign fail_o         = (samp_cnt_q != SampMax) | comma_q | buffer_q;
   assign latency_last_o = last_q;
   assign latency_min_o  = min_q;
   assign latency_max_o  = max_q;

endmodule

// File: rtl/link_latency_monitor.sv
// Multi-lane MGT loopback latency monitor. Generates a timestamped TX stream with periodic
// IDLE commas per lane and checks each RX lane for alignment, buffer health and latency.
//   clk_i, rst_n_i       : single clock, asynchronous active-low reset
//   clear_i              : clear statistics and sticky flags on all lanes
//   tx_data_o / tx_k_o   : TX symbols / K-flags, lane n at [n*W +: W] / [n*K +: K]
//   rx_data_i / rx_k_i   : RX symbols / K-flags
//   rx_synced_i, rx_buf_err_i, rx_rdy_i, rx_remote_rdy_i : per-lane PHY status
//   rx_resync_o, fail_o, fail_comma_o, fail_buffer_o     : per-lane status
//   latency_last_o/min_o/max_o (W per lane), latency_sum_o (W+16 per lane)
// Build option: define LINK_LATENCY_MONITOR_SUM_EN to build the latency accumulators;
// otherwise latency_sum_o is tied to zero.
module link_latency_monitor
   import link_latency_monitor_pkg::*;
#(
   parameter int unsigned g_NUM_LANES           = 4,
   parameter int unsigned g_DATA_WIDTH          = 16,
   parameter logic [15:0] g_IDLE                = IdleWordDefault,
   parameter logic [1:0]  g_IDLE_K              = IdleKDefault,
   parameter int unsigned g_IDLE_PERIOD         = 193,
   parameter int unsigned g_BLIND_PERIOD        = 10,
   parameter int unsigned g_NUM_SUCCESSFUL_DATA = 1000
) (
   input  logic                                          clk_i,
   input  logic                                          rst_n_i,
   input  logic                                          clear_i,
   output logic [g_NUM_LANES*g_DATA_WIDTH-1:0]           tx_data_o,
   output logic [g_NUM_LANES*(g_DATA_WIDTH/8)-1:0]       tx_k_o,
   input  logic [g_NUM_LANES*g_DATA_WIDTH-1:0]           rx_data_i,
   input  logic [g_NUM_LANES*(g_DATA_WIDTH/8)-1:0]       rx_k_i,
   input  logic [g_NUM_LANES-1:0]                        rx_synced_i,
   input  logic [g_NUM_LANES-1:0]                        rx_buf_err_i,
   input  logic [g_NUM_LANES-1:0]                        rx_rdy_i,
   input  logic [g_NUM_LANES-1:0]                        rx_remote_rdy_i,
   output logic [g_NUM_LANES-1:0]                        rx_resync_o,
   output logic [g_NUM_LANES-1:0]                        fail_o,
   output logic [g_NUM_LANES-1:0]                        fail_comma_o,
   output logic [g_NUM_LANES-1:0]                        fail_buffer_o,
   output logic [g_NUM_LANES*g_DATA_WIDTH-1:0]           latency_last_o,
   output logic [g_NUM_LANES*g_DATA_WIDTH-1:0]           latency_min_o,
   output logic [g_NUM_LANES*g_DATA_WIDTH-1:0]           latency_max_o,
   output logic [g_NUM_LANES*(g_DATA_WIDTH+16)-1:0]      latency_sum_o
);

   localparam int unsigned N  = g_NUM_LANES;
   localparam int unsigned W  = g_DATA_WIDTH;
   localparam int unsigned K  = k_width(g_DATA_WIDTH);
   localparam int unsigned SW = W + 16;
   localparam int unsigned IdleCntW = cnt_width(g_IDLE_PERIOD - 1);
   localparam logic [IdleCntW-1:0] IdleLast = IdleCntW'(g_IDLE_PERIOD - 1);
   localparam logic [W-1:0] IdleW  = W'(g_IDLE);
   localparam logic [K-1:0] IdleKW = K'(g_IDLE_K);

   logic [W-1:0]         ts_q;
   logic [IdleCntW-1:0]  idle_cnt_q;
   logic [N*W-1:0]       tx_data_q, tx_data_d;
   logic [N*K-1:0]       tx_k_q, tx_k_d;

   always_comb begin
      tx_data_d = tx_data_q;
      tx_k_d    = tx_k_q;
      for (int n = 0; n < int'(N); n++) begin
         if (!rx_remote_rdy_i[n] || (idle_cnt_q == '0)) begin
            tx_data_d[n*W +: W] = IdleW;
            tx_k_d[n*K +: K]    = IdleKW;
         end else begin
            tx_data_d[n*W +: W] = ts_q;
            tx_k_d[n*K +: K]    = '0;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         ts_q       <= '0;
         idle_cnt_q <= '0;
         tx_data_q  <= {N{IdleW}};
         tx_k_q     <= {N{IdleKW}};
      end else begin
         ts_q       <= ts_q + 1'b1;
         idle_cnt_q <= (idle_cnt_q == IdleLast) ? '0 : idle_cnt_q + 1'b1;
         tx_data_q  <= tx_data_d;
         tx_k_q     <= tx_k_d;
      end
   end

   assign tx_data_o = tx_data_q;
   assign tx_k_o    = tx_k_q;

   for (genvar n = 0; n < N; n++) begin : g_lane
      link_latency_lane #(
         .g_DATA_WIDTH          (W),
         .g_K_WIDTH             (K),
         .g_IDLE_W              (IdleW),
         .g_IDLE_K_W            (IdleKW),
         .g_BLIND_PERIOD        (g_BLIND_PERIOD),
         .g_NUM_SUCCESSFUL_DATA (g_NUM_SUCCESSFUL_DATA)
      ) u_lane (
         .clk_i          (clk_i),
         .rst_n_i        (rst_n_i),
         .clear_i        (clear_i),
         .ts_i           (ts_q),
         .rx_data_i      (rx_data_i[n*W +: W]),
         .rx_k_i         (rx_k_i[n*K +: K]),
         .rx_synced_i    (rx_synced_i[n]),
         .rx_buf_err_i   (rx_buf_err_i[n]),
         .rx_rdy_i       (rx_rdy_i[n]),
         .rx_resync_o    (rx_resync_o[n]),
         .fail_o         (fail_o[n]),
         .fail_comma_o   (fail_comma_o[n]),
         .fail_buffer_o  (fail_buffer_o[n]),
         .latency_last_o (latency_last_o[n*W +: W]),
         .latency_min_o  (latency_min_o[n*W +: W]),
         .latency_max_o  (latency_max_o[n*W +: W]),
         .latency_sum_o  (latency_sum_o[n*SW +: SW])
      );
   end

endmodule
